// File: rtl/jump_pkg.sv
// Shared definitions for the ID/EX jump-target resolver.
// Jump type encodings and PC offsets used by jump_target_unit.
package jump_pkg;

    typedef enum logic [1:0] {
        JT_NONE = 2'b00,
        JT_J    = 2'b01,
        JT_JAL  = 2'b10,
        JT_JR   = 2'b11
    } jtype_e;

    localparam int unsigned PC_INC   = 4;
    localparam int unsigned LINK_OFF = 8;

endpackage

// File: rtl/jump_ras.sv
// Circular return-address stack; a full push overwrites the oldest entry.
// Push and pop are never requested in the same cycle.
module jump_ras
    import jump_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [ADDR_W-1:0]          push_data_i,
    output logic [ADDR_W-1:0]          top_o,
    output logic [$clog2(RAS_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    // ptr_q addresses the next free slot; top sits just below it
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (count_q != FULL)
                count_d = count_q + (PTR_W+1)'(1);
        end else if (pop_i && count_q != '0) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (push_i)
                mem_q[ptr_q] <= push_data_i;
        end
    end

    assign top_o   = mem_q[ptr_q - PTR_W'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/jump_target_unit.sv
// Registered J/JAL/JR target resolver with return-address prediction.
// Define JUMP_ALIGN_CHECK_EN to add align_err_o for misaligned JR targets.
module jump_target_unit
    import jump_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int TARGET_W  = 26,
    parameter int RAS_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  logic [1:0]                 jtype_i,
    input  logic [TARGET_W-1:0]        target_i,
    input  logic [ADDR_W-1:0]          reg_data_i,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    output logic                       jump_valid_o,
    output logic [ADDR_W-1:0]          jump_addr_o,
    output logic [ADDR_W-1:0]          ras_pred_o,
    output logic                       ras_hit_o,
    output logic                       mispredict_o,
    output logic [$clog2(RAS_DEPTH):0] ras_count_o
`ifdef JUMP_ALIGN_CHECK_EN
    ,
    output logic                       align_err_o
`endif
);

    localparam logic [ADDR_W-1:0] HI_MASK =
        {ADDR_W{1'b1}} << (TARGET_W + 2);

    jtype_e              jt;
    logic                accept, is_jr;
    logic [ADDR_W-1:0]   pc4, link, jaddr, tgt_ext, top;
    logic                nonempty, hit;
    logic [$clog2(RAS_DEPTH):0] count;

    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   pred_q, pred_d;
    logic                hit_q, hit_d;
    logic                mis_q, mis_d;

    assign jt      = jtype_e'(jtype_i);
    assign accept  = valid_i && jt != JT_NONE && !stall_i && !flush_i;
    assign is_jr   = jt == JT_JR;
    assign pc4     = pc_i + ADDR_W'(PC_INC);
    assign link    = pc_i + ADDR_W'(LINK_OFF);
    assign tgt_ext = ADDR_W'({target_i, 2'b00});
    assign jaddr   = (pc4 & HI_MASK) | tgt_ext;

    jump_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept && jt == JT_JAL),
        .pop_i       (accept && is_jr),
        .push_data_i (link),
        .top_o       (top),
        .count_o     (count)
    );

    assign nonempty = count != '0;
    assign hit      = nonempty && top == reg_data_i;

    // flush beats stall; idle cycles drop the pulse but keep addr/pred
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        pred_d  = pred_q;
        hit_d   = hit_q;
        mis_d   = mis_q;
        unique case (1'b1)
            flush_i, !stall_i && !accept: begin
                valid_d = 1'b0;
                hit_d   = 1'b0;
                mis_d   = 1'b0;
            end
            stall_i: ;
            default: begin
                valid_d = 1'b1;
                addr_d  = is_jr ? reg_data_i : jaddr;
                pred_d  = is_jr && nonempty ? top : '0;
                hit_d   = is_jr && hit;
                mis_d   = is_jr && !hit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            pred_q  <= '0;
            hit_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            pred_q  <= pred_d;
            hit_q   <= hit_d;
            mis_q   <= mis_d;
        end
    end

`ifdef JUMP_ALIGN_CHECK_EN
    logic align_q, align_d;

    always_comb begin
        align_d = align_q;
        if (flush_i || (!stall_i && !accept))
            align_d = 1'b0;
        else if (accept)
            align_d = is_jr && reg_data_i[1:0] != 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            align_q <= 1'b0;
        else
            align_q <= align_d;
    end

    assign align_err_o = align_q;
`endif

    assign jump_valid_o = valid_q;
    assign jump_addr_o  = addr_q;
    assign ras_pred_o   = pred_q;
    assign ras_hit_o    = hit_q;
    assign mispredict_o = mis_q;
    assign ras_count_o  = count;

endmodule

// File: tb/tb_jump_target_unit.sv
// Scoreboard bench for jump_target_unit: directed requests push
// expected results; a negedge monitor pops and compares them.
module tb_jump_target_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i = 1'b0;
    logic [1:0]  jtype_i = 2'b00;
    logic [25:0] target_i = '0;
    logic [31:0] reg_data_i = '0;
    logic [31:0] pc_i = '0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        jump_valid_o;
    logic [31:0] jump_addr_o;
    logic [31:0] ras_pred_o;
    logic        ras_hit_o;
    logic        mispredict_o;
    logic [3:0]  ras_count_o;
    logic        align_err_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pred;
        logic        hit;
        logic        mis;
        logic        al;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic hold_q = 1'b0;

    jump_target_unit #(
        .ADDR_W    (32),
        .TARGET_W  (26),
        .RAS_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .jtype_i      (jtype_i),
        .target_i     (target_i),
        .reg_data_i   (reg_data_i),
        .pc_i         (pc_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .jump_valid_o (jump_valid_o),
        .jump_addr_o  (jump_addr_o),
        .ras_pred_o   (ras_pred_o),
        .ras_hit_o    (ras_hit_o),
        .mispredict_o (mispredict_o),
`ifdef JUMP_ALIGN_CHECK_EN
        .ras_count_o  (ras_count_o),
        .align_err_o  (align_err_o)
`else
        .ras_count_o  (ras_count_o)
`endif
    );

`ifndef JUMP_ALIGN_CHECK_EN
    assign align_err_o = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    // a stalled edge re-presents the same output; do not pop it twice
    always @(posedge clk) hold_q <= stall_i && !flush_i;

    always @(negedge clk) begin
        if (rst_n && !hold_q && jump_valid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(jump_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("addr", jump_addr_o, e.addr);
                chk("pred", ras_pred_o, e.pred);
                chk("hit", 32'(ras_hit_o), 32'(e.hit));
                chk("mis", 32'(mispredict_o), 32'(e.mis));
`ifdef JUMP_ALIGN_CHECK_EN
                chk("align", 32'(align_err_o), 32'(e.al));
`endif
            end
        end
    end

    task automatic req(input logic [1:0]  jt,
                       input logic [25:0] tgt,
                       input logic [31:0] rd,
                       input logic [31:0] pc,
                       input logic        fl,
                       input logic        acc,
                       input logic [31:0] ea,
                       input logic [31:0] ep,
                       input logic        eh,
                       input logic        em,
                       input logic        eal);
        valid_i    = 1'b1;
        jtype_i    = jt;
        target_i   = tgt;
        reg_data_i = rd;
        pc_i       = pc;
        flush_i    = fl;
        if (acc)
            q.push_back('{ea, ep, eh, em, eal});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic cnt(input string name, input int exp);
        chk(name, 32'(ras_count_o), 32'(exp));
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(jump_valid_o), 32'd0);
        chk("rst_addr", jump_addr_o, 32'd0);
        chk("rst_pred", ras_pred_o, 32'd0);
        chk("rst_hit", 32'(ras_hit_o), 32'd0);
        chk("rst_mis", 32'(mispredict_o), 32'd0);
        chk("rst_align", 32'(align_err_o), 32'd0);
        cnt("rst_count", 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // J
        req(2'b01, 26'h40, '0, 32'h1000_0000, 0, 1,
            32'h1000_0100, 0, 0, 0, 0);
        cnt("j_count", 0);

        // JAL then matching JR
        req(2'b10, 26'h010_0040, '0, 32'h0040_0010, 0, 1,
            32'h0040_0100, 0, 0, 0, 0);
        cnt("jal_count", 1);
        req(2'b11, '0, 32'h0040_0018, '0, 0, 1,
            32'h0040_0018, 32'h0040_0018, 1, 0, 0);
        cnt("jr_count", 0);

        // JR on empty stack
        req(2'b11, '0, 32'h0040_0200, '0, 0, 1,
            32'h0040_0200, 0, 0, 1, 0);
        cnt("jr_empty_count", 0);

        // JR whose prediction disagrees
        req(2'b10, '0, '0, 32'h0000_2000, 0, 1,
            32'h0000_0000, 0, 0, 0, 0);
        req(2'b11, '0, 32'h0000_3000, '0, 0, 1,
            32'h0000_3000, 32'h0000_2008, 0, 1, 0);
        cnt("jr_mismatch_count", 0);

        // overfill: nine JALs into eight entries
        for (int k = 1; k <= 9; k++)
            req(2'b10, '0, '0, 32'(k * 32'h100), 0, 1,
                32'h0, 0, 0, 0, 0);
        cnt("full_count", 8);
        for (int i = 9; i >= 2; i--) begin
            a = 32'(i * 32'h100 + 8);
            req(2'b11, '0, a, '0, 0, 1, a, a, 1, 0, 0);
        end
        cnt("drained_count", 0);
        req(2'b11, '0, 32'h0000_0108, '0, 0, 1,
            32'h0000_0108, 0, 0, 1, 0);
        cnt("underflow_count", 0);

        // flushed JAL: no pulse, no push
        req(2'b10, '0, '0, 32'h0000_0400, 1, 0, 0, 0, 0, 0, 0);
        chk("flush_valid", 32'(jump_valid_o), 32'd0);
        cnt("flush_count", 0);

        // jtype none with valid
        req(2'b00, '0, '0, 32'h0000_0800, 0, 0, 0, 0, 0, 0, 0);
        chk("none_valid", 32'(jump_valid_o), 32'd0);

        // stall for three cycles after a JAL
        req(2'b10, 26'h10, '0, 32'h0000_0500, 0, 1,
            32'h0000_0040, 0, 0, 0, 0);
        cnt("stall_pre_count", 1);
        valid_i    = 1'b1;
        jtype_i    = 2'b11;
        reg_data_i = 32'h0000_0508;
        stall_i    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(jump_valid_o), 32'd1);
            chk("stall_addr", jump_addr_o, 32'h0000_0040);
            cnt("stall_count", 1);
        end
        stall_i = 1'b0;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("post_stall_valid", 32'(jump_valid_o), 32'd0);

        // misaligned JR; top is 0x508 so it mispredicts
        req(2'b11, '0, 32'h0040_0002, '0, 0, 1,
            32'h0040_0002, 32'h0000_0508, 0, 1, 1);
        cnt("align_count", 0);

        // reset in the middle of a live output
        req(2'b10, '0, '0, 32'h0000_0600, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_valid", 32'(jump_valid_o), 32'd1);
        cnt("pre_rst_count", 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(jump_valid_o), 32'd0);
        chk("mid_rst_addr", jump_addr_o, 32'd0);
        cnt("mid_rst_count", 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        req(2'b01, 26'h40, '0, 32'h1000_0000, 0, 1,
            32'h1000_0100, 0, 0, 0, 0);
        cnt("after_rst_count", 0);
        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
